// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: stall/bubble
// bit positions, controller states and the core-wide reset/NOP constants.
package pipe_ctrl_pkg;

    localparam logic RstEnable  = 1'b0;
    localparam logic RstDisable = 1'b1;

    localparam logic [4:0] NOPRegAddr   = 5'b00000;
    localparam logic       WriteDisable = 1'b0;

    localparam int STALL_PC     = 0;
    localparam int STALL_IF_ID  = 1;
    localparam int STALL_ID_EX  = 2;
    localparam int STALL_EX_MEM = 3;
    localparam int STALL_MEM_WB = 4;

    localparam int BUB_IF_ID  = 0;
    localparam int BUB_ID_EX  = 1;
    localparam int BUB_EX_MEM = 2;
    localparam int BUB_MEM_WB = 3;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        WAIT_IF = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Stall/flush control bundle between the pipeline stages (master) and the
// central controller (slave).
interface pipe_ctrl_if #(
    parameter int ADDR_W     = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  stallreq_if;
    logic                  stallreq_ex;
    logic                  stallreq_mem;
    logic                  ex_is_load;
    logic [REG_ADDR_W-1:0] ex_wd;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_rs1_used;
    logic                  id_rs2_used;
    logic                  branch_req;
    logic [ADDR_W-1:0]     branch_target;
    logic [5:0]            stall;
    logic [3:0]            bubble;
    logic                  pc_redirect;
    logic [ADDR_W-1:0]     redirect_pc;
    logic                  busy;

    modport master (
        output stallreq_if, stallreq_ex, stallreq_mem, ex_is_load, ex_wd,
               id_rs1, id_rs2, id_rs1_used, id_rs2_used, branch_req, branch_target,
        input  stall, bubble, pc_redirect, redirect_pc, busy
    );

    modport slave (
        input  stallreq_if, stallreq_ex, stallreq_mem, ex_is_load, ex_wd,
               id_rs1, id_rs2, id_rs1_used, id_rs2_used, branch_req, branch_target,
        output stall, bubble, pc_redirect, redirect_pc, busy
    );
endinterface

// File: rtl/pipe_ctrl_hazard.sv
// Load-use comparator: flags an ID instruction that reads the register a load
// in EX is about to write. Register zero never creates a dependency.
module pipe_ctrl_hazard
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  ex_is_load,
    input  logic [REG_ADDR_W-1:0] ex_wd,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic                  id_rs1_used,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs2_used,
    output logic                  load_use
);
    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = id_rs1_used && (id_rs1 == ex_wd);
    assign rs2_hit  = id_rs2_used && (id_rs2 == ex_wd);
    assign load_use = ex_is_load && (ex_wd != REG_ADDR_W'(NOPRegAddr)) && (rs1_hit || rs2_hit);
endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush controller for the 5-stage RV32I pipeline.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int REG_ADDR_W = 5
`ifdef PIPE_CTRL_PERF_EN
    , parameter int PERF_W   = 32
`endif
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave bus
`ifdef PIPE_CTRL_PERF_EN
    , input  logic              perf_clr
    , output logic [PERF_W-1:0] perf_stall_cycles
    , output logic [PERF_W-1:0] perf_loaduse
    , output logic [PERF_W-1:0] perf_flush
`endif
);
    ctrl_state_e       state_q, state_d;
    logic [ADDR_W-1:0] pend_target_q, pend_target_d;
    logic              load_use;
    logic              lu_evt;
    logic [5:0]        stall_c;
    logic [3:0]        bubble_c;
    logic              redir_c;
    logic [ADDR_W-1:0] rpc_c;
    logic              in_reset;

    pipe_ctrl_hazard #(.REG_ADDR_W(REG_ADDR_W)) u_hazard (
        .ex_is_load  (bus.ex_is_load),
        .ex_wd       (bus.ex_wd),
        .id_rs1      (bus.id_rs1),
        .id_rs1_used (bus.id_rs1_used),
        .id_rs2      (bus.id_rs2),
        .id_rs2_used (bus.id_rs2_used),
        .load_use    (load_use)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            state_q       <= RUN;
            pend_target_q <= '0;
        end else begin
            state_q       <= state_d;
            pend_target_q <= pend_target_d;
        end
    end

    // Priority: MEM, EX, branch, pending redirect, load-use, IF.
    always_comb begin
        state_d       = state_q;
        pend_target_d = pend_target_q;
        stall_c       = '0;
        bubble_c      = '0;
        redir_c       = 1'b0;
        rpc_c         = '0;
        lu_evt        = 1'b0;
        if (bus.stallreq_mem) begin
            stall_c[STALL_MEM_WB:STALL_PC] = '1;
        end else if (bus.stallreq_ex) begin
            stall_c[STALL_EX_MEM:STALL_PC] = '1;
            bubble_c[BUB_EX_MEM]           = 1'b1;
        end else if (bus.branch_req) begin
            bubble_c[BUB_IF_ID] = 1'b1;
            bubble_c[BUB_ID_EX] = 1'b1;
            if (!bus.stallreq_if) begin
                redir_c = 1'b1;
                rpc_c   = bus.branch_target;
                state_d = RUN;
            end else begin
                pend_target_d     = bus.branch_target;
                state_d           = WAIT_IF;
                stall_c[STALL_PC] = 1'b1;
            end
        end else if (state_q == WAIT_IF) begin
            // The fetch that returns now belongs to the wrong path: drop it.
            bubble_c[BUB_IF_ID] = 1'b1;
            if (bus.stallreq_if) begin
                stall_c[STALL_PC] = 1'b1;
            end else begin
                redir_c = 1'b1;
                rpc_c   = pend_target_q;
                state_d = RUN;
            end
        end else if (load_use) begin
            stall_c[STALL_IF_ID:STALL_PC] = '1;
            bubble_c[BUB_ID_EX]           = 1'b1;
            lu_evt                        = 1'b1;
        end else if (bus.stallreq_if) begin
            stall_c[STALL_PC]   = 1'b1;
            bubble_c[BUB_IF_ID] = 1'b1;
        end
    end

    assign in_reset        = (rst == RstEnable);
    assign bus.stall       = in_reset ? 6'b0 : stall_c;
    assign bus.bubble      = in_reset ? 4'b0 : bubble_c;
    assign bus.pc_redirect = in_reset ? 1'b0 : redir_c;
    assign bus.redirect_pc = in_reset ? '0 : rpc_c;
    assign bus.busy        = in_reset ? 1'b0 : (state_q != RUN);

`ifdef PIPE_CTRL_PERF_EN
    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v, input logic en);
        if (en && (v != {PERF_W{1'b1}}))
            return v + PERF_W'(1);
        return v;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            perf_stall_cycles <= '0;
            perf_loaduse      <= '0;
            perf_flush        <= '0;
        end else if (perf_clr) begin
            perf_stall_cycles <= '0;
            perf_loaduse      <= '0;
            perf_flush        <= '0;
        end else begin
            perf_stall_cycles <= sat_inc(perf_stall_cycles, stall_c[STALL_PC]);
            perf_loaduse      <= sat_inc(perf_loaduse, lu_evt);
            perf_flush        <= sat_inc(perf_flush, redir_c);
        end
    end
`endif
endmodule
